// File: rtl/stack_engine.sv
// stack_engine: stack/link unit for the multi-cycle core.
//
// Runs PUSH, POP, CALL and RET as single memory transactions with a wait-state handshake.
// The stack is full-descending: SP points at the most recently pushed word and is
// STACK_TOP when the stack is empty. PUSH/CALL write at SP-1; POP/RET read at SP.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i           command request; accepted when cmd_ready_o is high
//   cmd_ready_o           high only while idle
//   cmd_op_i              0=PUSH 1=POP 2=CALL 3=RET
//   cmd_data_i            PUSH data / CALL return address
//   cmd_target_i          CALL destination
//   sp_load_i             load SP from sp_load_data_i (idle, no command, in range only)
//   sp_load_data_i        new SP value
//   mem_req_o             memory transaction active
//   mem_we_o              1=write, 0=read; valid while mem_req_o
//   mem_addr_o            transaction address
//   mem_wdata_o           write data
//   mem_rdata_i           read data, valid with mem_ack_i on a read
//   mem_ack_i             transaction complete
//   pop_data_o            last popped value
//   pc_out_o              new PC for CALL/RET
//   pc_load_o             one-cycle PC load strobe
//   sp_o                  current stack pointer
//   depth_o               STACK_TOP - SP
//   done_o                one-cycle command completion strobe
//   overflow_o            with done_o: PUSH/CALL rejected, stack full
//   underflow_o           with done_o: POP/RET rejected, stack empty

module stack_engine #(
  parameter int unsigned          DATA_W      = 16,
  parameter int unsigned          ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]    STACK_TOP   = ADDR_W'(32'h8000),
  parameter logic [ADDR_W-1:0]    STACK_LIMIT = ADDR_W'(32'h7F00)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [ADDR_W-1:0] cmd_target_i,
  input  logic              sp_load_i,
  input  logic [ADDR_W-1:0] sp_load_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] depth_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [1:0] OpPush = 2'd0;
  localparam logic [1:0] OpPop  = 2'd1;
  localparam logic [1:0] OpCall = 2'd2;
  localparam logic [1:0] OpRet  = 2'd3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMem  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic accept;
  logic cmd_is_write;
  logic sp_load_ok;

  assign accept       = cmd_valid_i && (state_q == StIdle);
  // PUSH and CALL share op bit 0 == 0.
  assign cmd_is_write = ~cmd_op_i[0];
  assign sp_load_ok   = (sp_load_data_i >= STACK_LIMIT) && (sp_load_data_i <= STACK_TOP);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    sp_d        = sp_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop_data_d  = pop_data_q;
    pc_out_d    = pc_out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = cmd_op_i;
          target_d = cmd_target_i;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          if (cmd_is_write) begin
            if (sp_q == STACK_LIMIT) begin
              ovf_d   = 1'b1;
              state_d = StFin;
            end else begin
              state_d     = StMem;
              mem_we_d    = 1'b1;
              mem_addr_d  = sp_q - ADDR_W'(1);
              mem_wdata_d = cmd_data_i;
            end
          end else begin
            if (sp_q == STACK_TOP) begin
              unf_d   = 1'b1;
              state_d = StFin;
            end else begin
              state_d    = StMem;
              mem_we_d   = 1'b0;
              mem_addr_d = sp_q;
            end
          end
        end else if (sp_load_i && sp_load_ok) begin
          // A concurrent command always takes priority over an SP load.
          sp_d = sp_load_data_i;
        end
      end

      StMem: begin
        // Request signals stay frozen in their registers until the ack arrives.
        if (mem_ack_i) begin
          state_d = StFin;
          if (!op_q[0]) begin
            sp_d = sp_q - ADDR_W'(1);
            if (op_q == OpCall) begin
              pc_out_d = target_q;
            end
          end else begin
            sp_d       = sp_q + ADDR_W'(1);
            pop_data_d = mem_rdata_i;
            if (op_q == OpRet) begin
              // Truncates or zero-extends the return address to ADDR_W.
              pc_out_d = ADDR_W'(mem_rdata_i);
            end
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= OpPush;
      target_q    <= '0;
      sp_q        <= STACK_TOP;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pop_data_q  <= '0;
      pc_out_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      sp_q        <= sp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pop_data_q  <= pop_data_d;
      pc_out_q    <= pc_out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign mem_req_o   = (state_q == StMem);
  assign mem_we_o    = mem_req_o && mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign pop_data_o  = pop_data_q;
  assign pc_out_o    = pc_out_q;
  assign sp_o        = sp_q;
  assign depth_o     = STACK_TOP - sp_q;
  assign done_o      = (state_q == StFin);
  assign overflow_o  = done_o && ovf_q;
  assign underflow_o = done_o && unf_q;
  // CALL and RET share op bit 1; only successful ones load the PC.
  assign pc_load_o   = done_o && op_q[1] && !ovf_q && !unf_q;

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised stack/link unit for the next-generation multi-cycle core.
- Replaces the bare SP register with an FSM that executes PUSH, POP, CALL and RET as memory transactions with a wait-state handshake.
- Maintains SP with overflow/underflow protection and drives PC load requests for CALL and RET.
- Sits between the control unit (command handshake) and the memory/SysBus interface.

Parameters:
DATA_W, 16, data/return-address width
ADDR_W, 16, memory address and SP width
STACK_TOP, 'h8000, SP value when empty; stack grows downward, full-descending
STACK_LIMIT, 'h7F00, lowest legal SP (full); must satisfy STACK_LIMIT < STACK_TOP

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high
CmdValid  input  1  command request
CmdReady  output  1  high only in IDLE
CmdOp  input  2  0=PUSH 1=POP 2=CALL 3=RET
CmdData  input  DATA_W  PUSH data / CALL return address
CmdTarget  input  ADDR_W  CALL destination
SpLoad  input  1  load SP from SpLoadData (IDLE only)
SpLoadData  input  ADDR_W  new SP
MemReq  output  1  memory transaction active
MemWe  output  1  1=write, 0=read; valid while MemReq
MemAddr  output  ADDR_W  transaction address
MemWData  output  DATA_W  write data
MemRData  input  DATA_W  read data, valid with MemAck on a read
MemAck  input  1  transaction complete
PopData  output  DATA_W  last popped value
PcOut  output  ADDR_W  new PC for CALL/RET
PcLoad  output  1  one-cycle PC load strobe
Sp  output  ADDR_W  current stack pointer
Depth  output  ADDR_W  STACK_TOP - Sp
Done  output  1  one-cycle command completion strobe
Overflow  output  1  one-cycle strobe with Done; PUSH/CALL rejected
Underflow  output  1  one-cycle strobe with Done; POP/RET rejected

Behaviour:
- Reset values:
  - Sp = STACK_TOP; Depth = 0.
  - MemReq, MemWe, PcLoad, Done, Overflow, Underflow = 0.
  - PopData, PcOut, MemAddr, MemWData = 0.
  - CmdReady = 1; state IDLE.
- States: IDLE, MEM, FIN.
- IDLE:
  - Command accepted when CmdValid & CmdReady; operands are latched.
  - PUSH/CALL with Sp == STACK_LIMIT: -> FIN with Overflow; no memory access, Sp unchanged.
  - POP/RET with Sp == STACK_TOP: -> FIN with Underflow; no memory access, Sp unchanged.
  - Otherwise -> MEM. Next cycle: MemReq = 1.
    - PUSH/CALL: MemWe = 1, MemAddr = Sp-1, MemWData = CmdData.
    - POP/RET: MemWe = 0, MemAddr = Sp.
  - SpLoad in IDLE without CmdValid: Sp <= SpLoadData if STACK_LIMIT <= SpLoadData <= STACK_TOP; otherwise ignored.
  - SpLoad together with CmdValid: command wins, SpLoad ignored.
  - SpLoad outside IDLE: ignored.
- MEM:
  - MemReq, MemWe, MemAddr and MemWData are held stable until MemAck is sampled high. Unbounded wait states are allowed.
  - MemAck while MemReq is low is ignored.
  - On MemAck, -> FIN and MemReq drops the next cycle:
    - PUSH: Sp <= Sp-1.
    - CALL: Sp <= Sp-1; PcOut <= CmdTarget.
    - POP: Sp <= Sp+1; PopData <= MemRData.
    - RET: Sp <= Sp+1; PopData <= MemRData; PcOut <= MemRData[ADDR_W-1:0], zero-extended when DATA_W < ADDR_W.
- FIN:
  - Done = 1 for one cycle.
  - PcLoad = 1 only for successful CALL/RET.
  - Overflow/Underflow asserted if the command was rejected.
  - -> IDLE; CmdReady returns the cycle after FIN.
- Latency:
  - Accept at cycle 0; MemReq from cycle 1.
  - Zero-wait MemAck at cycle 1 -> Done at cycle 2.
  - Rejected commands: Done at cycle 1.
- Arithmetic: Sp is ADDR_W-bit modular. Wrap cannot occur because the bounds checks precede every update. Depth is combinational from Sp.
- Back-to-back: a new command may be presented during FIN but is accepted only once back in IDLE (one idle cycle minimum between accepts).
- Reset mid-operation: Reset in MEM abandons the transaction. MemReq is 0 the next cycle, Sp = STACK_TOP, no Done. A late MemAck after reset is ignored.

Test Plan:
- Reset, then PUSH CmdData=16'hBEEF, MemAck on 1st MEM cycle -> MemAddr=16'h7FFF, MemWe=1, Done at cycle 2, Sp=16'h7FFF, Depth=1.
- POP with MemAck delayed 3 cycles, MemRData=16'hBEEF -> MemReq/MemAddr=16'h7FFF stable 4 cycles, PopData=16'hBEEF, Sp=16'h8000, Done one cycle.
- CALL CmdData=16'h0123 CmdTarget=16'h0400, then RET returning 16'h0123 -> CALL: PcLoad with PcOut=16'h0400. RET: PcLoad with PcOut=16'h0123, Sp back to 16'h8000.
- POP at Sp=16'h8000 -> no MemReq, Done+Underflow at cycle 1, Sp unchanged. SpLoad 16'h7F00 then PUSH -> Done+Overflow at cycle 1, no MemReq.
- SpLoad 16'h9000 (out of range) -> Sp unchanged. SpLoad asserted together with CmdValid=PUSH -> PUSH executes, SpLoad ignored.
- Reset asserted in MEM mid-PUSH with MemAck low -> next cycle MemReq=0, Sp=16'h8000, no Done. MemAck pulse afterwards -> no state change.
